ps2_scancode_decoder: RTL

PS2_SCANCODE_DECODER -- requirements
Module: ps2_scancode_decoder

---
 rtl/ps2_scancode_decoder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: folds E0/E1/F0 prefix sequences into key events,
// buffers them in a small FIFO and tracks whether either shift key is held.
module ps2_scancode_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       slowClk,
    input  logic       reset,
    input  logic       received,
    input  logic [7:0] value,
    input  logic       error,
    input  logic       keyPop,
    output logic       keyValid,
    output logic [7:0] keyCode,
    output logic       keyExtended,
    output logic       keyRelease,
    output logic       shiftHeld,
    output logic       overflow
);
    localparam int         AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] EXT    = 3'd1;
    localparam logic [2:0] BRK    = 3'd2;
    localparam logic [2:0] EXTBRK = 3'd3;
    localparam logic [2:0] PAUSE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          lshift_q, lshift_d;
    logic          rshift_q, rshift_d;
    logic          shift_held_q, shift_held_d;
    logic [9:0]    mem_q [FIFO_DEPTH];

    logic       emit;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_rel;
    logic       is_noise;
    logic       is_fake_shift;
    logic       pop_ok;
    logic       push_ok;
    logic       full;
    logic [9:0] head;

    // Keyboard status/ack bytes that never represent a key.
    assign is_noise = (value == 8'h00) || (value == 8'hAA) || (value == 8'hEE) ||
                      (value == 8'hFA) || (value == 8'hFC) || (value == 8'hFE) ||
                      (value == 8'hFF);
    assign is_fake_shift = (value == 8'h12) || (value == 8'h59);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        emit    = 1'b0;
        ev_code = value;
        ev_ext  = 1'b0;
        ev_rel  = 1'b0;
        if (error) begin
            state_d = IDLE;
        end else if (received) begin
            case (state_q)
                IDLE: begin
                    if (value == 8'hE0) begin
                        state_d = EXT;
                    end else if (value == 8'hF0) begin
                        state_d = BRK;
                    end else if (value == 8'hE1) begin
                        state_d = PAUSE;
                        skip_d  = 3'd7;
                    end else if (!is_noise) begin
                        emit = 1'b1;
                    end
                end
                EXT: begin
                    if (value == 8'hF0) begin
                        state_d = EXTBRK;
                    end else if (value != 8'hE0) begin
                        state_d = IDLE;
                        emit    = !is_fake_shift;
                        ev_ext  = 1'b1;
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    emit    = 1'b1;
                    ev_rel  = 1'b1;
                end
                EXTBRK: begin
                    state_d = IDLE;
                    emit    = !is_fake_shift;
                    ev_ext  = 1'b1;
                    ev_rel  = 1'b1;
                end
                PAUSE: begin
                    // The whole 8-byte Pause sequence collapses into one E0 77 make.
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) begin
                        state_d = IDLE;
                        emit    = 1'b1;
                        ev_code = 8'h77;
                        ev_ext  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign full    = (count_q == DEPTH_C);
    assign pop_ok  = keyPop && (count_q != '0);
    assign push_ok = emit && (!full || pop_ok);

    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop_ok) count_d = count_q + (AW + 1)'(1);
        if (!push_ok && pop_ok) count_d = count_q - (AW + 1)'(1);
        overflow_d = overflow_q || (emit && full && !pop_ok);
        // Shift tracking follows every emitted event, even one the FIFO drops.
        lshift_d   = lshift_q;
        rshift_d   = rshift_q;
        if (emit && !ev_ext && ev_code == 8'h12) lshift_d = !ev_rel;
        if (emit && !ev_ext && ev_code == 8'h59) rshift_d = !ev_rel;
        shift_held_d = lshift_d || rshift_d;
    end

    always_ff @(posedge slowClk) begin
        if (reset) begin
            state_q      <= IDLE;
            skip_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            lshift_q     <= 1'b0;
            rshift_q     <= 1'b0;
            shift_held_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            lshift_q     <= lshift_d;
            rshift_q     <= rshift_d;
            shift_held_q <= shift_held_d;
        end
    end

    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge slowClk) begin
                if (!reset && push_ok && wr_ptr_q == AW'(gi)) begin
                    mem_q[gi] <= {ev_code, ev_ext, ev_rel};
                end
            end
        end
    endgenerate

    // Head fields are forced to zero when empty so the post-reset view is defined.
    assign head        = mem_q[rd_ptr_q];
    assign keyValid    = (count_q != '0);
    assign keyCode     = keyValid ? head[9:2] : 8'h00;
    assign keyExtended = keyValid && head[1];
    assign keyRelease  = keyValid && head[0];
    assign shiftHeld   = shift_held_q;
    assign overflow    = overflow_q;

endmodule
